bneck_scheduler: RTL
====================

# bneck_scheduler

Sequencing controller for one MobileNetV3 bottleneck block executed on time-shared stage engines. It walks the output feature map in row tiles and, for each tile, issues expand, depthwise, pointwise and optional shortcut-conv passes. After the last tile it issues the optional squeeze-excite pass and then the residual-add pass. Each pass uses a start/done handshake, and a watchdog guards against a hung engine. It sits between the network-level layer controller and the block's conv/BN/activation/SE engines.

## Interface
- OUT_HEIGHT, 56: output rows of the block (≥1)
- TILE_ROWS, 8: output rows per tile (1..OUT_HEIGHT)
- TIMEOUT_CYCLES, 65535: maximum cycles a stage may remain outstanding
- N_TILES (localparam) = ceil(OUT_HEIGHT/TILE_ROWS); TW = $clog2(N_TILES+1); RW = $clog2(OUT_HEIGHT+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request; accepted only in IDLE
- abort  in  1  synchronous abort of a running block
- cfg_use_se  in  1  enable SE stage; sampled on accepted start
- cfg_shortcut  in  2  0 none, 1 direct, 2 conv, 3 reserved (treated as 0); sampled on accepted start
- stage_done  in  6  per-engine completion pulses: bit0 EXP, 1 DW, 2 PW, 3 SC, 4 SE, 5 ADD
- stage_start  out  6  one-hot one-cycle start pulse, same bit order
- stage_id  out  3  index of outstanding stage; 7 when none
- tile_idx  out  TW  current tile
- tile_row_base  out  RW  first output row of current tile = tile_idx*TILE_ROWS
- tile_rows  out  RW  rows in current tile = min(TILE_ROWS, OUT_HEIGHT − tile_row_base)
- busy  out  1  high from cycle after accepted start until done/abort
- done  out  1  one-cycle completion pulse
- error  out  1  sticky watchdog flag; cleared on next accepted start

## Operation
- FSM states are IDLE, ISSUE, WAIT.
- IDLE:
  - start=1 latches cfg, clears tile_idx and error, then goes to ISSUE with stage EXP.
- ISSUE (exactly one cycle):
  - drives stage_start[stage]=1, loads watchdog with 0, goes to WAIT.
- WAIT:
  - stage_done[stage]=1 advances to the next stage and returns to ISSUE.
  - stage_done bits of other stages are ignored.
  - The watchdog increments every WAIT cycle. When it equals TIMEOUT_CYCLES without a matching done: set error=1, pulse done, go to IDLE.
- Stage order within a tile: EXP → DW → PW → SC. SC is skipped unless cfg_shortcut=2.
- After the tile's final stage:
  - if tile_idx < N_TILES−1, increment tile_idx and issue EXP;
  - otherwise issue SE if cfg_use_se, then ADD if cfg_shortcut∈{1,2}, then finish.
- Finish: done=1 for one cycle, return to IDLE. tile_idx holds its last value.
- Skipped stages cost zero cycles: the next stage's ISSUE follows the completing WAIT directly.
- abort:
  - In ISSUE/WAIT: go to IDLE next cycle, no done pulse, error unchanged.
  - In IDLE: ignored.
  - abort has priority over stage_done and the watchdog in the same cycle.
- start while busy is ignored; cfg changes while busy have no effect.
- stage_done coincident with watchdog expiry counts as success, with no error.
- stage_id and tile outputs are registered, change only on state transitions, and are valid whenever busy=1.

## Timing
- Reset values:
  - FSM IDLE
  - stage_start=0, stage_id=7
  - tile_idx=0, tile_row_base=0, tile_rows=min(TILE_ROWS,OUT_HEIGHT)
  - busy=0, done=0, error=0
- Start accepted at cycle 0: busy=1 and stage_start[EXP]=1 at cycle 1.
- stage_done sampled at cycle k:
  - next stage_start at cycle k+1;
  - or, for the last stage, done=1 and busy=0 at cycle k+1.
- A new start at cycle k+1 is accepted (done cycle is in IDLE).
- Minimum block time with all engines responding the cycle after start: 2 cycles per issued stage, +1 for done.
- Watchdog: stage_start at cycle s with no matching done → error=1, done=1 at cycle s+TIMEOUT_CYCLES+1.
- stage_done arriving in the ISSUE cycle itself is ignored; engines respond no earlier than the cycle after stage_start.
- Reset mid-run forces reset values immediately (asynchronously); no done pulse.

## Test plan
- OUT_HEIGHT=20, TILE_ROWS=8, use_se=1, shortcut=2, engines answer 3 cycles after start → stage sequence (EXP,DW,PW,SC)×3 then SE, ADD (14 starts). tile_row_base 0/8/16, tile_rows 8/8/4. Single done, error=0.
- Same geometry, use_se=0, shortcut=0 → 9 starts, no SC/SE/ADD pulses. Done at cycle 1+9·4... checked per the handshake rule.
- shortcut=1, use_se=0, immediate responders → stage_start spacing exactly 2 cycles. ADD is issued last. Back-to-back start in the done cycle is accepted.
- TIMEOUT_CYCLES=10, DW never answers → error=1 and done at s+11. busy low, stage_id=7. Next start clears error.
- abort during tile 1 PW WAIT, with a simultaneous PW done → IDLE next cycle, no done, no further stage_start.
- Spurious stage_done[SE] during EXP wait, plus start pulses while busy → both ignored, sequence unchanged. Async rst mid-WAIT → all outputs at reset values immediately.

Source files
------------

// File: rtl/bneck_scheduler.sv
// Sequencing controller for one MobileNetV3 bottleneck block: walks output row
// tiles, issuing EXP/DW/PW/SC per tile, then SE and ADD, with a per-stage watchdog.
module bneck_scheduler #(
  parameter int OUT_HEIGHT     = 56,
  parameter int TILE_ROWS      = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int N_TILES = (OUT_HEIGHT + TILE_ROWS - 1) / TILE_ROWS,
  localparam int TW      = $clog2(N_TILES + 1),
  localparam int RW      = $clog2(OUT_HEIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cfg_use_se,
  input  logic [1:0]    cfg_shortcut,
  input  logic [5:0]    stage_done,
  output logic [5:0]    stage_start,
  output logic [2:0]    stage_id,
  output logic [TW-1:0] tile_idx,
  output logic [RW-1:0] tile_row_base,
  output logic [RW-1:0] tile_rows,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    fsm_state
);

  localparam int WW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FIRST_ROWS = (TILE_ROWS < OUT_HEIGHT) ? TILE_ROWS : OUT_HEIGHT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ST_EXP  = 3'd0,
    ST_DW   = 3'd1,
    ST_PW   = 3'd2,
    ST_SC   = 3'd3,
    ST_SE   = 3'd4,
    ST_ADD  = 3'd5,
    ST_NONE = 3'd7
  } stage_e;

  // Handshake: stage_start[i] is a one-cycle request for engine i; the engine
  // answers with a one-cycle stage_done[i] no earlier than the next cycle. Only
  // the done bit of the outstanding stage is observed, and only while waiting.

  state_e        state_q, state_d;
  stage_e        stage_q, stage_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [RW-1:0] base_q, base_d;
  logic [RW-1:0] rows_q, rows_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          use_se_q, use_se_d;
  logic [1:0]    sc_q, sc_d;

  stage_e        adv_stage;
  logic          adv_tile;
  logic          last_tile;
  logic          done_hit;
  logic          wd_expire;
  logic [RW-1:0] base_next;
  logic [RW-1:0] rows_next;
  int            rem;

  function automatic logic [5:0] stage_onehot(input stage_e s);
    logic [5:0] oh;
    oh = '0;
    case (s)
      ST_EXP:  oh = 6'b000001;
      ST_DW:   oh = 6'b000010;
      ST_PW:   oh = 6'b000100;
      ST_SC:   oh = 6'b001000;
      ST_SE:   oh = 6'b010000;
      ST_ADD:  oh = 6'b100000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  assign done_hit  = |(stage_done & stage_onehot(stage_q));
  assign wd_expire = (wd_q == WW'(TIMEOUT_CYCLES - 1));

  // Successor of the stage that just completed; ST_NONE means the block is finished.
  always_comb begin
    adv_stage = ST_NONE;
    adv_tile  = 1'b0;
    last_tile = (tile_q == TW'(N_TILES - 1));
    case (stage_q)
      ST_EXP: adv_stage = ST_DW;
      ST_DW:  adv_stage = ST_PW;
      ST_PW, ST_SC: begin
        if (stage_q == ST_PW && sc_q == 2'd2) begin
          adv_stage = ST_SC;
        end else if (!last_tile) begin
          adv_stage = ST_EXP;
          adv_tile  = 1'b1;
        end else if (use_se_q) begin
          adv_stage = ST_SE;
        end else if (sc_q != 2'd0) begin
          adv_stage = ST_ADD;
        end
      end
      ST_SE: begin
        if (sc_q != 2'd0) adv_stage = ST_ADD;
      end
      default: adv_stage = ST_NONE;
    endcase
  end

  // Geometry of the following tile; only consumed when another tile exists.
  always_comb begin
    base_next = base_q + RW'(TILE_ROWS);
    rem       = OUT_HEIGHT - int'(base_next);
    rows_next = (rem < TILE_ROWS) ? RW'(rem) : RW'(TILE_ROWS);
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    tile_d   = tile_q;
    base_d   = base_q;
    rows_d   = rows_q;
    wd_d     = wd_q;
    done_d   = 1'b0;
    error_d  = error_q;
    use_se_d = use_se_q;
    sc_d     = sc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          stage_d  = ST_EXP;
          tile_d   = '0;
          base_d   = '0;
          rows_d   = RW'(FIRST_ROWS);
          error_d  = 1'b0;
          use_se_d = cfg_use_se;
          sc_d     = (cfg_shortcut == 2'd3) ? 2'd0 : cfg_shortcut;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
          stage_d = ST_NONE;
        end else begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        // abort beats a done; a done beats a watchdog expiry in the same cycle
        if (abort) begin
          state_d = S_IDLE;
          stage_d = ST_NONE;
        end else if (done_hit) begin
          if (adv_stage == ST_NONE) begin
            state_d = S_IDLE;
            stage_d = ST_NONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            stage_d = adv_stage;
            if (adv_tile) begin
              tile_d = tile_q + TW'(1);
              base_d = base_next;
              rows_d = rows_next;
            end
          end
        end else if (wd_expire) begin
          state_d = S_IDLE;
          stage_d = ST_NONE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = ST_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stage_q  <= ST_NONE;
      tile_q   <= '0;
      base_q   <= '0;
      rows_q   <= RW'(FIRST_ROWS);
      wd_q     <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      use_se_q <= 1'b0;
      sc_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      tile_q   <= tile_d;
      base_q   <= base_d;
      rows_q   <= rows_d;
      wd_q     <= wd_d;
      done_q   <= done_d;
      error_q  <= error_d;
      use_se_q <= use_se_d;
      sc_q     <= sc_d;
    end
  end

  assign stage_start   = (state_q == S_ISSUE) ? stage_onehot(stage_q) : 6'b000000;
  assign stage_id      = stage_q;
  assign tile_idx      = tile_q;
  assign tile_row_base = base_q;
  assign tile_rows     = rows_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign fsm_state     = state_q;

endmodule
